// File: rtl/uart_link_pkg.sv
// Shared constants and state types for the byte UART link.
package uart_link_pkg;

    // Oversample ticks per bit and the tick on which the start bit is checked
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    // Addresses the core's IO decode uses for this port
    localparam logic [15:0] UART_DATA_ADDR = 16'h1000;
    localparam logic [15:0] UART_STAT_ADDR = 16'h2000;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } txState_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rxState_t;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO. Its pointers carry an extra wrap bit so that full and
// empty can be told apart. A push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle; otherwise it is ignored.
module sync_byte_fifo
    import uart_link_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] pushData_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       empty_o,
    output logic       full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0] mem_q [DEPTH];
    logic [AW:0] wrPtr_q, wrPtr_d;
    logic [AW:0] rdPtr_q, rdPtr_d;
    logic        doPush;
    logic        doPop;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);
    assign head_o  = mem_q[rdPtr_q[AW-1:0]];

    // Advance each pointer when its operation is actually performed
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + (AW+1)'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + (AW+1)'(1);
        end
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage array; contents are only visible through head_o when non-empty
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= pushData_i;
        end
    end

endmodule

// File: rtl/uart_byte_link.sv
// Byte UART link: queues CPU writes and sends them as 8N1 frames on uart_txd,
// and collects 8N1 frames from uart_rxd into a FIFO the CPU can read. Both
// directions run off a shared 16x oversample tick.
module uart_byte_link
    import uart_link_pkg::*;
#(
    parameter int DIV      = 54,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart0_wr,
    input  logic [7:0] uart_w,
    input  logic       uart0_rd,
    output logic       uart0_valid,
    output logic [7:0] uart0_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       uart_txd,
    input  logic       uart_rxd,
    input  logic       err_clr,
    output logic       tx_overflow,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int               DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [3:0]       TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]       MID_LAST  = 4'(MID_SAMPLE - 1);

    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic             tick;

    logic       txPop;
    logic [7:0] txHead;
    logic       txEmpty;
    logic       txFull;

    txState_t   txState_q, txState_d;
    logic [3:0] txTickCnt_q, txTickCnt_d;
    logic [2:0] txBitCnt_q, txBitCnt_d;
    logic [7:0] txShift_q, txShift_d;

    logic       rxSync1_q, rxSync2_q;
    logic       rxdS;

    rxState_t   rxState_q, rxState_d;
    logic [3:0] rxTickCnt_q, rxTickCnt_d;
    logic [2:0] rxBitCnt_q, rxBitCnt_d;
    logic [7:0] rxShift_q, rxShift_d;
    logic       rxPush;
    logic       rxFrameErrSet;
    logic [7:0] rxHead;
    logic       rxEmpty;
    logic       rxFull;

    logic txOverflowSet, rxOverrunSet;
    logic txOverflow_q, txOverflow_d;
    logic rxOverrun_q, rxOverrun_d;
    logic rxFrameErr_q, rxFrameErr_d;

    assign tick = (divCnt_q == DIV_LAST);

    // Oversample tick divider: counts 0..DIV-1 and wraps on the tick cycle
    always_comb begin
        divCnt_d = divCnt_q + DIV_W'(1);
        if (tick) begin
            divCnt_d = '0;
        end
    end

    // Divider register, free-running from reset
    always_ff @(posedge clk) begin
        if (reset) begin
            divCnt_q <= '0;
        end else begin
            divCnt_q <= divCnt_d;
        end
    end

    sync_byte_fifo #(.DEPTH(TX_DEPTH)) txFifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (uart0_wr),
        .pushData_i (uart_w),
        .pop_i      (txPop),
        .head_o     (txHead),
        .empty_o    (txEmpty),
        .full_o     (txFull)
    );

    // TX next state: each state holds for 16 ticks; frames start on a tick from IDLE
    always_comb begin
        txState_d   = txState_q;
        txTickCnt_d = txTickCnt_q;
        txBitCnt_d  = txBitCnt_q;
        txShift_d   = txShift_q;
        txPop       = 1'b0;
        case (txState_q)
            TX_IDLE: begin
                if (tick && !txEmpty) begin
                    txPop       = 1'b1;
                    txShift_d   = txHead;
                    txTickCnt_d = '0;
                    txBitCnt_d  = '0;
                    txState_d   = TX_START;
                end
            end
            TX_START: begin
                if (tick) begin
                    if (txTickCnt_q == TICK_LAST) begin
                        txTickCnt_d = '0;
                        txState_d   = TX_DATA;
                    end else begin
                        txTickCnt_d = txTickCnt_q + 4'd1;
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (txTickCnt_q == TICK_LAST) begin
                        txTickCnt_d = '0;
                        txShift_d   = {1'b1, txShift_q[7:1]};
                        if (txBitCnt_q == 3'd7) begin
                            txState_d = TX_STOP;
                        end else begin
                            txBitCnt_d = txBitCnt_q + 3'd1;
                        end
                    end else begin
                        txTickCnt_d = txTickCnt_q + 4'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (txTickCnt_q == TICK_LAST) begin
                        txTickCnt_d = '0;
                        txState_d   = TX_IDLE;
                    end else begin
                        txTickCnt_d = txTickCnt_q + 4'd1;
                    end
                end
            end
            default: begin
                txState_d = TX_IDLE;
            end
        endcase
    end

    // TX state registers; reset aborts any frame in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            txState_q   <= TX_IDLE;
            txTickCnt_q <= '0;
            txBitCnt_q  <= '0;
            txShift_q   <= '0;
        end else begin
            txState_q   <= txState_d;
            txTickCnt_q <= txTickCnt_d;
            txBitCnt_q  <= txBitCnt_d;
            txShift_q   <= txShift_d;
        end
    end

    // Line level follows the TX state; data goes out LSB first from the shifter
    always_comb begin
        uart_txd = 1'b1;
        case (txState_q)
            TX_START: uart_txd = 1'b0;
            TX_DATA:  uart_txd = txShift_q[0];
            default:  uart_txd = 1'b1;
        endcase
    end

    assign tx_ready = !txFull;
    assign tx_busy  = (txState_q != TX_IDLE) || !txEmpty;

    // Two-flop synchroniser for the asynchronous receive pin, idling high
    always_ff @(posedge clk) begin
        if (reset) begin
            rxSync1_q <= 1'b1;
            rxSync2_q <= 1'b1;
        end else begin
            rxSync1_q <= uart_rxd;
            rxSync2_q <= rxSync1_q;
        end
    end

    assign rxdS = rxSync2_q;

    // RX next state: qualify the start bit at mid-bit, then sample every 16 ticks
    always_comb begin
        rxState_d     = rxState_q;
        rxTickCnt_d   = rxTickCnt_q;
        rxBitCnt_d    = rxBitCnt_q;
        rxShift_d     = rxShift_q;
        rxPush        = 1'b0;
        rxFrameErrSet = 1'b0;
        case (rxState_q)
            RX_IDLE: begin
                if (!rxdS) begin
                    rxTickCnt_d = '0;
                    rxState_d   = RX_START;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rxTickCnt_q == MID_LAST) begin
                        rxTickCnt_d = '0;
                        rxBitCnt_d  = '0;
                        rxState_d   = rxdS ? RX_IDLE : RX_DATA;
                    end else begin
                        rxTickCnt_d = rxTickCnt_q + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rxTickCnt_q == TICK_LAST) begin
                        rxTickCnt_d = '0;
                        rxShift_d   = {rxdS, rxShift_q[7:1]};
                        if (rxBitCnt_q == 3'd7) begin
                            rxState_d = RX_STOP;
                        end else begin
                            rxBitCnt_d = rxBitCnt_q + 3'd1;
                        end
                    end else begin
                        rxTickCnt_d = rxTickCnt_q + 4'd1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (rxTickCnt_q == TICK_LAST) begin
                        rxTickCnt_d = '0;
                        if (rxdS) begin
                            rxPush    = 1'b1;
                            rxState_d = RX_IDLE;
                        end else begin
                            rxFrameErrSet = 1'b1;
                            rxState_d     = RX_WAIT_HIGH;
                        end
                    end else begin
                        rxTickCnt_d = rxTickCnt_q + 4'd1;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rxdS) begin
                    rxState_d = RX_IDLE;
                end
            end
            default: begin
                rxState_d = RX_IDLE;
            end
        endcase
    end

    // RX state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rxState_q   <= RX_IDLE;
            rxTickCnt_q <= '0;
            rxBitCnt_q  <= '0;
            rxShift_q   <= '0;
        end else begin
            rxState_q   <= rxState_d;
            rxTickCnt_q <= rxTickCnt_d;
            rxBitCnt_q  <= rxBitCnt_d;
            rxShift_q   <= rxShift_d;
        end
    end

    sync_byte_fifo #(.DEPTH(RX_DEPTH)) rxFifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (rxPush),
        .pushData_i (rxShift_q),
        .pop_i      (uart0_rd),
        .head_o     (rxHead),
        .empty_o    (rxEmpty),
        .full_o     (rxFull)
    );

    assign uart0_valid = !rxEmpty;
    assign uart0_data  = rxEmpty ? 8'h00 : rxHead;

    // A drop only counts when no pop frees a slot in the same cycle
    assign txOverflowSet = uart0_wr && txFull && !txPop;
    assign rxOverrunSet  = rxPush && rxFull && !uart0_rd;

    // Sticky error flags: cleared by err_clr, but a same-cycle set event wins
    always_comb begin
        txOverflow_d = txOverflow_q;
        rxOverrun_d  = rxOverrun_q;
        rxFrameErr_d = rxFrameErr_q;
        if (err_clr) begin
            txOverflow_d = 1'b0;
            rxOverrun_d  = 1'b0;
            rxFrameErr_d = 1'b0;
        end
        if (txOverflowSet) begin
            txOverflow_d = 1'b1;
        end
        if (rxOverrunSet) begin
            rxOverrun_d = 1'b1;
        end
        if (rxFrameErrSet) begin
            rxFrameErr_d = 1'b1;
        end
    end

    // Sticky flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            txOverflow_q <= 1'b0;
            rxOverrun_q  <= 1'b0;
            rxFrameErr_q <= 1'b0;
        end else begin
            txOverflow_q <= txOverflow_d;
            rxOverrun_q  <= rxOverrun_d;
            rxFrameErr_q <= rxFrameErr_d;
        end
    end

    assign tx_overflow  = txOverflow_q;
    assign rx_overrun   = rxOverrun_q;
    assign rx_frame_err = rxFrameErr_q;

endmodule

// File: tb/tb_uart_byte_link.sv
// Bench for uart_byte_link at DIV=2 (32 clocks per bit) with 16-entry FIFOs.
module tb_uart_byte_link;

    localparam int DIV      = 2;
    localparam int TX_DEPTH = 16;
    localparam int RX_DEPTH = 16;
    localparam int BIT      = 16 * DIV;
    // Clocks from the start-bit edge to the stop-bit sample when the edge is
    // driven just before a non-tick cycle: 2 sync flops, 1 to enter START,
    // then 8 + 9*16 ticks spaced DIV apart with the first one 1 clock later.
    localparam int RD_ALIGN = 3 + (8 - 1 + 16 * 9) * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart0_wr = 1'b0;
    logic [7:0] uart_w = 8'h00;
    logic       uart0_rd = 1'b0;
    logic       err_clr = 1'b0;
    logic       rxdDrv = 1'b1;
    logic       loopEn = 1'b0;
    logic       rxdLine;

    logic       uart0_valid;
    logic [7:0] uart0_data;
    logic       tx_ready;
    logic       tx_busy;
    logic       uart_txd;
    logic       tx_overflow;
    logic       rx_overrun;
    logic       rx_frame_err;

    int vectors = 0;
    int miscompares = 0;
    int tbDiv;

    assign rxdLine = loopEn ? uart_txd : rxdDrv;

    uart_byte_link #(.DIV(DIV), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .uart0_wr     (uart0_wr),
        .uart_w       (uart_w),
        .uart0_rd     (uart0_rd),
        .uart0_valid  (uart0_valid),
        .uart0_data   (uart0_data),
        .tx_ready     (tx_ready),
        .tx_busy      (tx_busy),
        .uart_txd     (uart_txd),
        .uart_rxd     (rxdLine),
        .err_clr      (err_clr),
        .tx_overflow  (tx_overflow),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    // Tick phase per the divider rule: 0..DIV-1 from reset, tick on DIV-1
    always @(posedge clk) begin
        if (reset) tbDiv <= 0;
        else       tbDiv <= (tbDiv == DIV - 1) ? 0 : tbDiv + 1;
    end

    function automatic logic frameBit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic writeByte(input logic [7:0] b);
        uart0_wr = 1'b1;
        uart_w   = b;
        @(negedge clk);
        uart0_wr = 1'b0;
    endtask

    task automatic readByte(output logic [7:0] d);
        d = uart0_data;
        uart0_rd = 1'b1;
        @(negedge clk);
        uart0_rd = 1'b0;
    endtask

    task automatic pulseErrClr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic sendRxFrame(input logic [7:0] b, input logic stopBit);
        rxdDrv = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxdDrv = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxdDrv = stopBit;
        repeat (BIT) @(negedge clk);
        rxdDrv = 1'b1;
    endtask

    // Decodes one frame from uart_txd by sampling mid-bit
    task automatic captureTxFrame(output logic [7:0] b, output bit ok);
        int waited = 0;
        b  = 8'h00;
        ok = 1'b0;
        while (uart_txd !== 1'b0 && waited < 4 * BIT) begin
            @(negedge clk);
            waited++;
        end
        if (uart_txd !== 1'b0) return;
        repeat (BIT / 2) @(negedge clk);
        if (uart_txd !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            b[i] = uart_txd;
        end
        repeat (BIT) @(negedge clk);
        ok = (uart_txd === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (uart_txd !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_txd: got %b want 1", uart_txd); end
        vectors++;
        if (uart0_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b want 0", uart0_valid); end
        vectors++;
        if (uart0_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_data: got %h want 00", uart0_data); end
        vectors++;
        if (tx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_tx_ready: got %b want 1", tx_ready); end
        vectors++;
        if (tx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_busy: got %b want 0", tx_busy); end
        vectors++;
        if ({tx_overflow, rx_overrun, rx_frame_err} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b want 000", {tx_overflow, rx_overrun, rx_frame_err});
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (uart_txd !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_txd: got %b want 1", uart_txd); end
    endtask

    task automatic test_tx_frame(input logic [7:0] b);
        int waited = 0;
        writeByte(b);
        vectors++;
        if (tx_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL tx_busy_after_write: got %b want 1", tx_busy); end
        while (uart_txd !== 1'b0 && waited < 4 * DIV + 4) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (uart_txd !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL tx_start_timeout: got txd %b want 0", uart_txd);
            return;
        end
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < BIT; c++) begin
                vectors++;
                if (uart_txd !== frameBit(b, k)) begin
                    miscompares++;
                    $display("[TB] FAIL tx_bit%0d_clk%0d byte %h: got %b want %b", k, c, b, uart_txd, frameBit(b, k));
                end
                @(negedge clk);
            end
        end
        vectors++;
        if (tx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_busy_after_stop: got %b want 0", tx_busy); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_loopback();
        logic [7:0] model[$];
        logic [7:0] b;
        logic [7:0] got;
        int waited = 0;
        model = '{8'h00, 8'hFF, 8'h55};
        for (int i = 0; i < 2; i++) model.push_back(8'($urandom));
        loopEn = 1'b1;
        foreach (model[i]) writeByte(model[i]);
        while (tx_busy === 1'b1 && waited < 10 * BIT * 8) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (tx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL loop_tx_done: got busy %b want 0", tx_busy); end
        repeat (2 * BIT) @(negedge clk);
        vectors++;
        if (uart0_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL loop_valid: got %b want 1", uart0_valid); end
        foreach (model[i]) begin
            readByte(got);
            vectors++;
            if (got !== model[i]) begin miscompares++; $display("[TB] FAIL loop_byte%0d: got %h want %h", i, got, model[i]); end
        end
        vectors++;
        if (uart0_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL loop_drained_valid: got %b want 0", uart0_valid); end
        vectors++;
        if ({tx_overflow, rx_overrun, rx_frame_err} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL loop_flags: got %b want 000", {tx_overflow, rx_overrun, rx_frame_err});
        end
        loopEn = 1'b0;
        b = 8'h00;
    endtask

    task automatic test_tx_overflow();
        logic [7:0] sent[17];
        logic [7:0] got[17];
        bit         okv[17];
        bit         sawLow = 1'b0;
        loopEn = 1'b0;
        rxdDrv = 1'b1;
        fork
            begin
                for (int i = 0; i < 17; i++) captureTxFrame(got[i], okv[i]);
            end
            begin
                for (int i = 0; i < 17; i++) begin
                    sent[i] = 8'($urandom);
                    uart0_wr = 1'b1;
                    uart_w   = sent[i];
                    @(negedge clk);
                end
                uart0_wr = 1'b0;
                vectors++;
                if (tx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_full_ready: got %b want 0", tx_ready); end
                vectors++;
                if (tx_overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_17_accepted: got %b want 0", tx_overflow); end
                writeByte(~sent[0]);
                vectors++;
                if (tx_overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_18th_dropped: got %b want 1", tx_overflow); end
                pulseErrClr();
                vectors++;
                if (tx_overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_err_clr: got %b want 0", tx_overflow); end
                err_clr  = 1'b1;
                uart0_wr = 1'b1;
                uart_w   = 8'hEE;
                @(negedge clk);
                err_clr  = 1'b0;
                uart0_wr = 1'b0;
                vectors++;
                if (tx_overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_set_wins: got %b want 1", tx_overflow); end
                pulseErrClr();
            end
        join
        for (int i = 0; i < 17; i++) begin
            vectors++;
            if (!okv[i] || got[i] !== sent[i]) begin
                miscompares++;
                $display("[TB] FAIL ovf_frame%0d: got %h framed %0d want %h", i, got[i], okv[i], sent[i]);
            end
        end
        for (int c = 0; c < 400; c++) begin
            if (uart_txd !== 1'b1) sawLow = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (sawLow) begin miscompares++; $display("[TB] FAIL ovf_no_extra_frame: got low txd want idle"); end
        vectors++;
        if (tx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_idle_busy: got %b want 0", tx_busy); end
    endtask

    task automatic test_rx_overrun();
        logic [7:0] model[$];
        logic [7:0] b;
        logic [7:0] got;
        bit         expOverrun = 1'b0;
        int         guard = 0;
        loopEn = 1'b0;
        rxdDrv = 1'b1;
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            if (model.size() < RX_DEPTH) model.push_back(b);
            else expOverrun = 1'b1;
            sendRxFrame(b, 1'b1);
        end
        repeat (BIT) @(negedge clk);
        vectors++;
        if (rx_overrun !== expOverrun) begin miscompares++; $display("[TB] FAIL rx_overrun_set: got %b want %b", rx_overrun, expOverrun); end
        vectors++;
        if (uart0_data !== model[0]) begin miscompares++; $display("[TB] FAIL rx_first_head: got %h want %h", uart0_data, model[0]); end
        pulseErrClr();
        vectors++;
        if (rx_overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL rx_overrun_clr: got %b want 0", rx_overrun); end
        // Line up the start edge with the tick phase so the read lands on the push
        while (tbDiv != 0 && guard < 4 * DIV) begin
            @(negedge clk);
            guard++;
        end
        b = 8'($urandom);
        fork
            sendRxFrame(b, 1'b1);
            begin
                repeat (RD_ALIGN) @(negedge clk);
                vectors++;
                if (uart0_data !== model[0]) begin miscompares++; $display("[TB] FAIL rx_head_before_pop: got %h want %h", uart0_data, model[0]); end
                uart0_rd = 1'b1;
                @(negedge clk);
                uart0_rd = 1'b0;
            end
        join
        void'(model.pop_front());
        model.push_back(b);
        repeat (4) @(negedge clk);
        vectors++;
        if (rx_overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL rx_push_pop_full: got overrun %b want 0", rx_overrun); end
        foreach (model[i]) begin
            readByte(got);
            vectors++;
            if (got !== model[i]) begin miscompares++; $display("[TB] FAIL rx_drain%0d: got %h want %h", i, got, model[i]); end
        end
        vectors++;
        if (uart0_valid !== 1'b0 || uart0_data !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL rx_empty: got valid %b data %h want 0 00", uart0_valid, uart0_data);
        end
        readByte(got);
        vectors++;
        if (uart0_valid !== 1'b0 || uart0_data !== 8'h00 || rx_overrun !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rx_read_empty: got valid %b data %h ovr %b want 0 00 0", uart0_valid, uart0_data, rx_overrun);
        end
    endtask

    task automatic test_frame_error();
        logic [7:0] got;
        sendRxFrame(8'h3C, 1'b0);
        rxdDrv = 1'b0;
        repeat (5 * BIT) @(negedge clk);
        rxdDrv = 1'b1;
        repeat (BIT) @(negedge clk);
        sendRxFrame(8'h81, 1'b1);
        repeat (BIT) @(negedge clk);
        vectors++;
        if (rx_frame_err !== 1'b1) begin miscompares++; $display("[TB] FAIL ferr_flag: got %b want 1", rx_frame_err); end
        readByte(got);
        vectors++;
        if (got !== 8'h81) begin miscompares++; $display("[TB] FAIL ferr_good_byte: got %h want 81", got); end
        vectors++;
        if (uart0_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL ferr_only_one: got valid %b want 0", uart0_valid); end
        pulseErrClr();
        vectors++;
        if (rx_frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL ferr_clr: got %b want 0", rx_frame_err); end
    endtask

    task automatic test_glitch();
        rxdDrv = 1'b0;
        repeat (4 * DIV) @(negedge clk);
        rxdDrv = 1'b1;
        repeat (20 * BIT) @(negedge clk);
        vectors++;
        if (uart0_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL glitch_no_push: got valid %b want 0", uart0_valid); end
        vectors++;
        if ({tx_overflow, rx_overrun, rx_frame_err} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL glitch_flags: got %b want 000", {tx_overflow, rx_overrun, rx_frame_err});
        end
    endtask

    task automatic test_reset_mid_frame();
        int  waited = 0;
        bit  sawLow = 1'b0;
        sendRxFrame(8'($urandom), 1'b1);
        repeat (BIT) @(negedge clk);
        vectors++;
        if (uart0_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_rx_loaded: got %b want 1", uart0_valid); end
        writeByte(8'($urandom));
        writeByte(8'($urandom));
        while (uart_txd !== 1'b0 && waited < 4 * DIV + 4) begin
            @(negedge clk);
            waited++;
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (uart_txd !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_in_start: got txd %b want 0", uart_txd); end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (uart_txd !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_reset_txd: got %b want 1", uart_txd); end
        vectors++;
        if (tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_txfifo: got busy %b ready %b want 0 1", tx_busy, tx_ready);
        end
        vectors++;
        if (uart0_valid !== 1'b0 || uart0_data !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_rxfifo: got valid %b data %h want 0 00", uart0_valid, uart0_data);
        end
        reset = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (uart_txd !== 1'b1) sawLow = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (sawLow) begin miscompares++; $display("[TB] FAIL mid_reset_stays_idle: got low txd want idle"); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_tx_frame(8'hA5);
        test_tx_frame(8'($urandom));
        test_loopback();
        test_tx_overflow();
        test_rx_overrun();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_byte_link.md
Name: uart_byte_link

Overview:
- Serial-line end of the CPU's byte UART port. Accepts one-cycle write strobes plus a byte from the IO decode, queues them, and serialises them as 8N1 frames on uart_txd.
- Deserialises 8N1 frames from uart_rxd into a receive FIFO. Presents the head byte with a valid flag and pops it on a one-cycle read strobe.
- Sits between the core's IO decode (address 0x1000 data, 0x2000 status) and the board pins.

Parameters:
- DIV, 54, clk cycles per oversample tick; bit time = 16*DIV clocks; legal range >= 2.
- TX_DEPTH, 16, TX FIFO entries; power of two, >= 2.
- RX_DEPTH, 16, RX FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- uart0_wr  in  1  one-cycle strobe: push uart_w into TX FIFO
- uart_w  in  8  byte to transmit
- uart0_rd  in  1  one-cycle strobe: pop RX FIFO head
- uart0_valid  out  1  RX FIFO non-empty
- uart0_data  out  8  RX FIFO head byte; 0 when empty
- tx_ready  out  1  TX FIFO not full
- tx_busy  out  1  frame in flight or TX FIFO non-empty
- uart_txd  out  1  serial out, idle high
- uart_rxd  in  1  serial in, asynchronous
- err_clr  in  1  clears all sticky error flags
- tx_overflow  out  1  sticky: a write was dropped because TX FIFO was full
- rx_overrun  out  1  sticky: a received byte was dropped because RX FIFO was full
- rx_frame_err  out  1  sticky: stop bit was sampled low

Behaviour:
- Reset: uart_txd=1; uart0_valid=0; uart0_data=0; tx_ready=1; tx_busy=0; all sticky flags 0; FIFOs emptied; tick counter 0; both FSMs IDLE. Reset mid-frame aborts the frame immediately and returns txd high in the next cycle.
- Tick generator: counter runs 0..DIV-1 and asserts tick for one cycle when the count is DIV-1. It free-runs from reset.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: on a tick with the FIFO non-empty, pop the FIFO into the shifter and enter START; txd goes low in the next cycle.
  - Each state lasts 16 ticks. DATA sends 8 bits LSB first. STOP drives 1.
  - After STOP, return to IDLE. Back-to-back frames therefore begin on the next tick, with no extra idle bit.
- TX FIFO rules:
  - uart0_wr while full: byte dropped, tx_overflow set.
  - uart0_wr while full in the same cycle as an FSM pop: the write is accepted.
- RX input: uart_rxd passes through a 2-FF synchroniser, giving rxd_s.
- RX FSM, states IDLE, START, DATA, STOP, WAIT_HIGH:
  - IDLE: when rxd_s=0, reset the tick phase count and enter START.
  - START: after 8 ticks, sample rxd_s. If 1, treat as a glitch and return to IDLE. If 0, enter DATA.
  - DATA: sample every 16 ticks, 8 samples, shift in LSB first.
  - STOP: sample after 16 ticks. If 1, push the byte and go to IDLE. If 0, discard the byte, set rx_frame_err, and go to WAIT_HIGH.
  - WAIT_HIGH: leave for IDLE when rxd_s=1, so a break condition is not re-sampled as a start bit.
- RX FIFO rules:
  - Push while full: byte dropped, rx_overrun set, contents unchanged.
  - Push and uart0_rd together while full: both happen; no overrun.
  - uart0_rd while empty: ignored, no state change.
  - uart0_data/uart0_valid are combinational from the FIFO head and reflect a push in the cycle after it. A pop updates them in the cycle after uart0_rd.
- Sticky flags: err_clr clears them. If err_clr and a set event occur in the same cycle, set wins.
- FIFO pointers carry one extra wrap bit for full/empty detection; wrap-around at DEPTH is exercised.

Decomposition:
- Package uart_link_pkg holds:
  - OVERSAMPLE=16 and MID_SAMPLE=8.
  - TX and RX state enums.
  - IO address constants UART_DATA_ADDR=16'h1000 and UART_STAT_ADDR=16'h2000.
- One sub-module, sync_byte_fifo (parameter DEPTH), is instantiated twice for TX and RX. It provides push, pop, head, empty and full, with push-when-full ignored internally.
- Tick generator and both FSMs live in the top module.

Test Plan:
- Reset, then DIV=2. uart0_wr with 0xA5 -> txd low for 32 clocks, then bits 1,0,1,0,0,1,0,1 at 32 clocks each, then high 32 clocks; tx_busy falls after the stop bit.
- Loopback txd->rxd, write 0x00, 0xFF, 0x55 back-to-back -> uart0_valid rises, reads return 0x00, 0xFF, 0x55 in order, then valid=0; no error flags.
- Write 17 bytes with TX_DEPTH=16 while the first frame is still in flight:
  - The first pops to the shifter, so all 17 are accepted and tx_overflow=0.
  - The 18th write with tx_ready=0 -> dropped, tx_overflow=1.
  - err_clr -> tx_overflow=0.
- Receive 17 frames without reading -> 16 buffered, rx_overrun=1, first read returns byte 1. Also drive push and pop in the same cycle when full -> no overrun.
- Drive rxd frame 0x3C with stop bit 0, hold low 5 bit times, then a good 0x81 -> rx_frame_err=1, 0x3C never appears, 0x81 is received.
- Drive rxd low pulse of 4*DIV clocks -> START aborts, no byte pushed, no flags. Reset asserted mid-TX-frame -> txd=1 the next cycle and FIFOs empty.
